// File: rtl/song_sequencer.sv
// Rhythm-game song sequencer: steps through song positions, judges fret presses and keeps score.
// Optional macro STREAK_BONUS_EN enables streak tracking and the double-score bonus.
module song_sequencer #(
    parameter int unsigned TICKS_PER_BEAT = 25000000,
    parameter int unsigned SONG_LEN       = 100
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       start,
    input  logic       pause,
    input  logic [4:0] note_in,
    input  logic [4:0] buttons_db,
    output logic [6:0] songDataPos,
    output logic       beat_tick,
    output logic       hit,
    output logic       miss,
    output logic [6:0] score,
    output logic       overflow,
    output logic [3:0] streak,
    output logic       playing,
    output logic       done
);

    localparam int unsigned CNT_W = $clog2(TICKS_PER_BEAT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_BEAT - 1);
    localparam logic [6:0] POS_LAST = 7'(SONG_LEN - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       pos_q, pos_d;
    logic [4:0]       note_q, note_d;
    logic             judged_q, judged_d;
    logic [6:0]       score_q, score_d;
    logic             ovf_q, ovf_d;
    logic [3:0]       streak_q, streak_d;
    logic             hit_q, hit_d;
    logic             miss_q, miss_d;
    logic             tick_q, tick_d;
    logic             playing_q, done_q;
    logic             hit_now;
    logic [7:0]       inc;
    logic [7:0]       sum;

    // State register
    always_ff @(posedge clk or posedge clear) begin
        if (clear) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_PLAY;
            ST_PLAY: if (!pause && (cnt_q == CNT_LAST) && !(pos_q < POS_LAST)) state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values and judgement pulses
    always_comb begin
        cnt_d    = cnt_q;
        pos_d    = pos_q;
        note_d   = note_q;
        judged_d = judged_q;
        score_d  = score_q;
        ovf_d    = ovf_q;
        streak_d = streak_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        tick_d   = 1'b0;
        hit_now  = 1'b0;
        inc      = 8'd1;
`ifdef STREAK_BONUS_EN
        if (streak_q >= 4'd4) inc = 8'd2;
`endif
        sum = {1'b0, score_q} + inc;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    cnt_d    = '0;
                    pos_d    = 7'd0;
                    note_d   = 5'd0;
                    judged_d = 1'b0;
                    score_d  = 7'd0;
                    ovf_d    = 1'b0;
                    streak_d = 4'd0;
                end
            end
            ST_PLAY: begin
                if (!pause) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // ROM data is valid one cycle after the position changes
                    if (cnt_q == CNT_W'(1)) note_d = note_in;
                    hit_now = (cnt_q >= CNT_W'(2)) && !judged_q && (note_q != 5'd0)
                              && (buttons_db == note_q);
                    if (hit_now) begin
                        hit_d    = 1'b1;
                        judged_d = 1'b1;
                        if (sum > 8'd127) begin
                            score_d = 7'd127;
                            ovf_d   = 1'b1;
                        end else begin
                            score_d = sum[6:0];
                        end
`ifdef STREAK_BONUS_EN
                        streak_d = (streak_q == 4'hF) ? 4'hF : streak_q + 4'd1;
`endif
                    end
                    if (cnt_q == CNT_LAST) begin
                        cnt_d    = '0;
                        judged_d = 1'b0;
                        if (!judged_q && !hit_now && (note_q != 5'd0)) begin
                            miss_d   = 1'b1;
                            streak_d = 4'd0;
                        end
                        if (pos_q < POS_LAST) begin
                            pos_d  = pos_q + 7'd1;
                            tick_d = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            cnt_q     <= '0;
            pos_q     <= 7'd0;
            note_q    <= 5'd0;
            judged_q  <= 1'b0;
            score_q   <= 7'd0;
            ovf_q     <= 1'b0;
            streak_q  <= 4'd0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            tick_q    <= 1'b0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pos_q     <= pos_d;
            note_q    <= note_d;
            judged_q  <= judged_d;
            score_q   <= score_d;
            ovf_q     <= ovf_d;
            streak_q  <= streak_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            tick_q    <= tick_d;
            playing_q <= (state_d == ST_PLAY);
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign songDataPos = pos_q;
    assign beat_tick   = tick_q;
    assign hit         = hit_q;
    assign miss        = miss_q;
    assign score       = score_q;
    assign overflow    = ovf_q;
    assign streak      = streak_q;
    assign playing     = playing_q;
    assign done        = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: short song (8 ticks x 4 positions) and a 128-position saturation song.
module tb_song_sequencer;

    logic       clk = 1'b0;
    logic       clear, start, pause, start2;
    logic [4:0] note_in, buttons_db;
    logic [6:0] songDataPos, score;
    logic       beat_tick, hit, miss, overflow, playing, done;
    logic [3:0] streak;
    logic [6:0] songDataPos2, score2;
    logic       beat_tick2, hit2, miss2, overflow2, playing2, done2;
    logic [3:0] streak2;
    logic [4:0] song_rom [4];

    int checks = 0;
    int errors = 0;
    int n_hit, n_miss, n_tick, n_both, play_cyc, first_tick;
    int exp_streak4, exp_ovf127;
    int exp_seq [6];
    int seq [6];

    always #5 clk = ~clk;

    song_sequencer #(.TICKS_PER_BEAT(8), .SONG_LEN(4)) dut (
        .clk(clk), .clear(clear), .start(start), .pause(pause),
        .note_in(note_in), .buttons_db(buttons_db), .songDataPos(songDataPos),
        .beat_tick(beat_tick), .hit(hit), .miss(miss), .score(score),
        .overflow(overflow), .streak(streak), .playing(playing), .done(done)
    );

    song_sequencer #(.TICKS_PER_BEAT(8), .SONG_LEN(128)) dut2 (
        .clk(clk), .clear(clear), .start(start2), .pause(1'b0),
        .note_in(5'b00001), .buttons_db(5'b00001), .songDataPos(songDataPos2),
        .beat_tick(beat_tick2), .hit(hit2), .miss(miss2), .score(score2),
        .overflow(overflow2), .streak(streak2), .playing(playing2), .done(done2)
    );

    // Registered song ROM model
    always @(posedge clk) note_in <= song_rom[songDataPos[1:0]];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_song(input logic [4:0] note, input logic [4:0] btn, input bit toggle,
                            input int pause_at, input int clear_at);
        bit finished;
        finished = 1'b0;
        for (int i = 0; i < 4; i++) song_rom[i] = note;
        buttons_db = btn;
        n_hit = 0; n_miss = 0; n_tick = 0; n_both = 0; play_cyc = 0; first_tick = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 200 && !finished; i++) begin
            if (playing) play_cyc++;
            if (hit) n_hit++;
            if (miss) n_miss++;
            if (hit && miss) n_both++;
            if (beat_tick) begin
                n_tick++;
                if (first_tick == 0) first_tick = play_cyc;
            end
            if (!playing) begin
                finished = 1'b1;
            end else begin
                if (play_cyc == pause_at) pause = 1'b1;
                if (play_cyc == pause_at + 5) pause = 1'b0;
                if (toggle) buttons_db = 5'(play_cyc);
                if (play_cyc == clear_at) begin
                    clear = 1'b1;
                    #1;
                    check("clr_playing", int'(playing), 0);
                    check("clr_done", int'(done), 0);
                    check("clr_pos", int'(songDataPos), 0);
                    check("clr_score", int'(score), 0);
                    check("clr_pulses", int'({hit, miss, beat_tick}), 0);
                    check("clr_streak", int'(streak), 0);
                    @(negedge clk) clear = 1'b0;
                    finished = 1'b1;
                end
            end
            if (!finished) @(negedge clk);
        end
        check("song_ends", int'(finished), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef STREAK_BONUS_EN
        exp_seq = '{1, 2, 3, 4, 6, 8};
        exp_streak4 = 4;
        exp_ovf127 = 1;
`else
        exp_seq = '{1, 2, 3, 4, 5, 6};
        exp_streak4 = 0;
        exp_ovf127 = 0;
`endif
        clear = 1'b1; start = 1'b0; start2 = 1'b0; pause = 1'b0; buttons_db = 5'd0;
        for (int i = 0; i < 4; i++) song_rom[i] = 5'd0;
        repeat (2) @(negedge clk);
        check("rst_playing", int'(playing), 0);
        check("rst_done", int'(done), 0);
        check("rst_pos", int'(songDataPos), 0);
        check("rst_score", int'({overflow, score}), 0);
        check("rst_streak", int'(streak), 0);
        clear = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_wait", int'(playing), 0);

        // All positions hit
        run_song(5'b00001, 5'b00001, 1'b0, -1, -1);
        check("a_hits", n_hit, 4);
        check("a_miss", n_miss, 0);
        check("a_ticks", n_tick, 3);
        check("a_cycles", play_cyc, 32);
        check("a_first_tick", first_tick, 9);
        check("a_score", int'(score), 4);
        check("a_done", int'(done), 1);
        check("a_pos", int'(songDataPos), 3);
        check("a_ovf", int'(overflow), 0);
        check("a_streak", int'(streak), exp_streak4);
        repeat (5) @(negedge clk);
        check("a_hold_score", int'(score), 4);
        check("a_hold_done", int'({done, songDataPos}), 128 + 3);

        // All positions missed
        run_song(5'b00100, 5'b00000, 1'b0, -1, -1);
        check("b_hits", n_hit, 0);
        check("b_miss", n_miss, 4);
        check("b_ticks", n_tick, 3);
        check("b_cycles", play_cyc, 32);
        check("b_score", int'(score), 0);
        check("b_streak", int'(streak), 0);

        // Rests with toggling buttons
        run_song(5'b00000, 5'b00000, 1'b1, -1, -1);
        check("c_judged", n_hit + n_miss, 0);
        check("c_score", int'(score), 0);

        // Partial and superset patterns are not hits
        run_song(5'b00011, 5'b00001, 1'b0, -1, -1);
        check("d_partial_hits", n_hit, 0);
        check("d_partial_miss", n_miss, 4);
        run_song(5'b00011, 5'b00111, 1'b0, -1, -1);
        check("d_super_hits", n_hit, 0);
        check("d_super_miss", n_miss, 4);

        // Pause for 5 cycles at counter 3
        run_song(5'b00001, 5'b00001, 1'b0, 4, -1);
        check("e_first_tick", first_tick, 14);
        check("e_cycles", play_cyc, 37);
        check("e_hits", n_hit, 4);
        check("e_score", int'(score), 4);
        check("e_both", n_both, 0);

        // Clear at position 2, counter 4, then replay
        run_song(5'b00001, 5'b00001, 1'b0, -1, 21);
        repeat (3) @(negedge clk);
        check("f_idle", int'({playing, done}), 0);
        check("f_idle_pos", int'(songDataPos), 0);
        run_song(5'b00001, 5'b00001, 1'b0, -1, -1);
        check("f_replay_hits", n_hit, 4);
        check("f_replay_score", int'(score), 4);

        // 128 hits saturate the score
        begin
            int h2, t2, m2, s6;
            bit fin;
            h2 = 0; t2 = 0; m2 = 0; s6 = -1; fin = 1'b0;
            @(negedge clk) start2 = 1'b1;
            @(negedge clk) start2 = 1'b0;
            for (int i = 0; i < 1500 && !fin; i++) begin
                if (beat_tick2) t2++;
                if (miss2) m2++;
                if (hit2) begin
                    if (h2 < 6) seq[h2] = int'(score2);
                    if (h2 == 5) s6 = int'(streak2);
                    h2++;
                    if (h2 == 127) exp_ovf127 = exp_ovf127 - int'(overflow2);
                end
                if (done2) fin = 1'b1;
                else @(negedge clk);
            end
            check("g_finished", int'(fin), 1);
            check("g_hits", h2, 128);
            check("g_ticks", t2, 127);
            check("g_miss", m2, 0);
            for (int i = 0; i < 6; i++) check($sformatf("g_seq%0d", i), seq[i], exp_seq[i]);
`ifdef STREAK_BONUS_EN
            check("g_streak6", s6, 6);
            check("g_streak_sat", int'(streak2), 15);
`else
            check("g_streak6", s6, 0);
            check("g_streak_sat", int'(streak2), 0);
`endif
            check("g_ovf_at127", exp_ovf127, 0);
            check("g_score", int'(score2), 127);
            check("g_ovf", int'(overflow2), 1);
            check("g_pos", int'(songDataPos2), 127);
            repeat (4) @(negedge clk);
            check("g_hold", int'({playing2, overflow2, score2}), 255);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 Parameter TICKS_PER_BEAT, default 25000000, clk cycles per song position (0.25 s at 100 MHz); SHALL be >= 4.
REQ-002 Parameter SONG_LEN, default 100, number of song positions played (1..128).
REQ-003 clk  input  1  system clock, all state rising-edge.
REQ-004 clear  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  level; sampled each cycle, acts in IDLE/DONE only.
REQ-006 pause  input  1  level; freezes beat timing while high.
REQ-007 note_in  input  5  song data for songDataPos, valid one clk after songDataPos changes (registered ROM).
REQ-008 buttons_db  input  5  debounced fret buttons.
REQ-009 songDataPos  output  7  current song position to ROM.
REQ-010 beat_tick  output  1  one-cycle pulse on each position advance.
REQ-011 hit / miss  output  1 each  one-cycle judgement pulses.
REQ-012 score  output  7  saturating hit score.
REQ-013 overflow  output  1  sticky, set when an increment saturates score.
REQ-014 streak  output  4  consecutive-hit count (see REQ-033).
REQ-015 playing / done  output  1 each  state flags.

Function
REQ-016 States IDLE, PLAY, DONE; playing=1 only in PLAY, done=1 only in DONE.
REQ-017 IDLE/DONE with start=1 -> PLAY next cycle; songDataPos=0, tick counter=0, score=0, overflow=0, streak=0, judged flag=0.
REQ-018 PLAY: tick counter increments 0..TICKS_PER_BEAT-1 per cycle when pause=0; holds all state (counter, latched note, judged flag) when pause=1.
REQ-019 Counter==1: note_q latched from note_in.
REQ-020 Counter>=2, judged=0, note_q!=0, buttons_db==note_q exactly: hit=1 that cycle, judged=1, score+=increment.
REQ-021 Wrong or partial patterns are not judged; only one hit per position.
REQ-022 Counter==TICKS_PER_BEAT-1 and pause=0: if note_q!=0 and judged=0, miss=1 that cycle and streak=0; counter->0, judged->0.
REQ-023 Same cycle: if songDataPos<SONG_LEN-1, songDataPos+1 and beat_tick=1; else state->DONE, songDataPos held, no beat_tick.
REQ-024 note_q==0 (rest): no hit, no miss, streak unchanged.
REQ-025 Score arithmetic 8-bit internally; result >127 -> score=127, overflow=1.
REQ-026 hit and miss never both 1 in one cycle; hit cannot occur at counter 0 or 1.
REQ-027 DONE holds score, overflow, songDataPos until start or clear.
REQ-028 start while in PLAY ignored.

Reset
REQ-029 clear=1 asynchronously forces IDLE, songDataPos=0, counter=0, note_q=0, judged=0, score=0, overflow=0, streak=0, all pulses 0.
REQ-030 clear mid-song aborts playback; no hit/miss pulse emitted in the clear cycle.
REQ-031 After clear deasserts, block remains IDLE until start.

Configuration
REQ-032 Macro STREAK_BONUS_EN.
REQ-033 Defined: streak increments per hit (saturates 15), zeroed on miss; a hit with streak>=4 before it adds 2, else 1.
REQ-034 Undefined: streak output constant 0, every hit adds 1.

Verification (TICKS_PER_BEAT=8, SONG_LEN=4)
REQ-035 clear, start pulse, note_in=00001 all positions, buttons_db=00001 held -> 4 hits (one per position at counter 2), 3 beat_ticks, done=1, score=4.
REQ-036 note_in=00100, buttons_db=00000 -> miss at counter 7 each position, score=0, done after 32 cycles in PLAY.
REQ-037 note_in=00000 every position, buttons toggling -> no hit/miss, score=0.
REQ-038 pause high 5 cycles at counter 3 -> songDataPos advance delayed exactly 5 cycles, judgements unchanged.
REQ-039 Preload score near 127 via SONG_LEN=128 all hits -> score=127, overflow=1 and holds; with STREAK_BONUS_EN, 6 hits -> score 1,2,3,4,6,8, streak=6.
REQ-040 clear asserted at position 2 counter 4 -> immediate IDLE, all outputs 0; start -> replays from songDataPos=0.
